fifo_burst_drain: RTL
=====================

// Module: fifo_burst_drain
// PURPOSE
//  Downstream consumer of the team's first-word-fall-through fifo. Drains it in framed bursts
//  onto a valid/ready stream: one header word, then up to BURST data words, m_last on the final
//  data word. Starts a full burst once BURST words are buffered; flushes a partial burst after
//  TIMEOUT idle cycles so trailing data never stalls.
// PARAMETERS
//  WIDTH    32    data width; must equal fifo WIDTH, must be >= 32
//  DEPTH    512   fifo DEPTH; sizes fifo_data_count
//  BURST    16    max data words per burst, 1..65535, must be <= DEPTH-1
//  TIMEOUT  1024  cycles in IDLE with 0 < count < BURST before a partial flush, >= 1
// PORTS
//  clk              in   1                 sole clock, rising edge
//  srst_n           in   1                 synchronous reset, active low
//  fifo_dout        in   WIDTH             fifo head word (FWFT: valid while !fifo_empty)
//  fifo_empty       in   1                 fifo empty
//  fifo_data_count  in   $clog2(DEPTH)     words held in fifo
//  fifo_rd_en       out  1                 pop head word; combinational
//  m_data           out  WIDTH             stream data
//  m_valid          out  1                 stream valid
//  m_ready          in   1                 stream ready
//  m_last           out  1                 final data word of burst
//  m_hdr            out  1                 current beat is the header
//  underrun         out  1                 sticky: fifo_empty seen while a data beat was owed
// BEHAVIOUR
//  Reset (srst_n=0 at posedge): state=IDLE, timer=0, seq=0, remain=0, underrun=0.
//   All outputs 0 while in IDLE. Reset mid-burst aborts it; no m_last issued; fifo words left.
//  Handshake: beat transfers when m_valid && m_ready. Once m_valid=1, m_data/m_hdr/m_last stay
//   stable until transfer. m_valid never depends combinationally on m_ready.
//  States:
//   IDLE: timer counts up (saturating at TIMEOUT) while 0 < fifo_data_count < BURST; cleared
//    to 0 when count==0 or on leaving IDLE. Go HEADER when count >= BURST (len=BURST) or
//    timer==TIMEOUT && count>0 (len=count). len latched into 16-bit register at transition.
//   HEADER: m_valid=1, m_hdr=1, m_data={seq[WIDTH-17:0], len[15:0]}. On transfer: seq<=seq+1
//    (wraps mod 2^(WIDTH-16)), remain<=len, go DATA.
//   DATA: m_valid=!fifo_empty, m_data=fifo_dout, m_last=(remain==1),
//    fifo_rd_en=m_valid && m_ready. On transfer remain<=remain-1; if remain==1 go IDLE.
//    fifo_empty=1 in DATA sets underrun (protocol error: this block is the sole reader).
//  Latency: IDLE->HEADER 1 cycle after trigger condition sampled; min burst duration len+1
//   cycles with m_ready held high; back-to-back bursts separated by exactly 1 IDLE cycle.
//  Boundaries: count==BURST exactly triggers a full burst (no timeout wait). Writes arriving
//   during a burst do not change len. Timer reaching TIMEOUT on the same cycle count reaches
//   BURST -> full burst (len=BURST). m_ready low indefinitely: state and outputs hold.
// STRUCTURE
//  Package fifo_burst_pkg: typedef enum logic [1:0] {IDLE, HEADER, DATA} burst_state_t;
//   localparam HDR_LEN_BITS=16; function make_hdr(seq, len) returning WIDTH-bit header.
//  One sub-module: sat_counter #(MAX) (clear, inc, count, at_max) used for the IDLE timer.
//  FSM, remain counter, seq counter and header mux stay in fifo_burst_drain.
// TESTING (bench instantiates fifo #(WIDTH=32,DEPTH=512) upstream, BURST=4, TIMEOUT=8)
//  1. Write 4 words 0x10..0x13, m_ready=1 -> hdr 0x0000_0004 (m_hdr=1), data 0x10..0x13,
//     m_last only on 0x13, 5 consecutive valid cycles; fifo empty after.
//  2. Write 2 words, wait -> no m_valid for 8 idle cycles, then hdr len=2 (seq=1 if after
//     test 1), 2 data words, m_last on second.
//  3. Write 9 words at once, m_ready=1 -> two full bursts (seq n, n+1) one IDLE cycle apart;
//     remaining 1 word flushed by timeout as len=1 burst.
//  4. m_ready toggled 1,0,0,1 random during burst -> m_data/m_last stable while stalled,
//     fifo_rd_en only on transfer cycles, stream order 0x10.. preserved.
//  5. srst_n=0 for 1 cycle after 2nd data beat -> next cycle m_valid=0, seq=0, underrun=0;
//     remaining words re-drained later with header seq=0.
//  6. Force fifo_empty=1 in DATA -> m_valid=0, underrun=1 and stays 1 until srst_n=0.

Source files
------------

// File: rtl/fifo_burst_pkg.sv
// Shared types and header packing for the framed FIFO burst drainer.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } burst_state_t;

  localparam int HDR_LEN_BITS  = 16;
  // Widest data path the header helper can pack; the top zero-pads seq up to it.
  localparam int HDR_MAX_WIDTH = 256;

  function automatic logic [HDR_MAX_WIDTH-1:0] make_hdr(
    input logic [HDR_MAX_WIDTH-HDR_LEN_BITS-1:0] seq,
    input logic [HDR_LEN_BITS-1:0]               len
  );
    return {seq, len};
  endfunction

endpackage

// File: rtl/fifo_burst_drain_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int MAX = 1024,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  always_ff @(posedge clk) begin
    if (!srst_n || clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

  assign at_max = (count == MAX_C);

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains a FWFT fifo in framed bursts (header + up to BURST data words) onto a valid/ready stream.
// state  | meaning
// IDLE   | waiting for BURST words buffered or the partial-flush timer to expire
// HEADER | presenting {seq, len} header beat
// DATA   | forwarding fifo head words until remain reaches zero
module fifo_burst_drain
  import fifo_burst_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 512,
  parameter int BURST   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     srst_n,
  input  logic [WIDTH-1:0]         fifo_dout,
  input  logic                     fifo_empty,
  input  logic [$clog2(DEPTH)-1:0] fifo_data_count,
  output logic                     fifo_rd_en,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     m_hdr,
  output logic                     underrun
);

  localparam int CW    = $clog2(DEPTH);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int SEQ_W = WIDTH - HDR_LEN_BITS;
  localparam int PAD   = HDR_MAX_WIDTH - WIDTH;

  localparam logic [CW-1:0]           BURST_C   = CW'(BURST);
  localparam logic [HDR_LEN_BITS-1:0] BURST_LEN = HDR_LEN_BITS'(BURST);
  localparam logic [TW-1:0]           TIMER_MAX = TW'(TIMEOUT);

  burst_state_t            state_q;
  logic [SEQ_W-1:0]        seq_q;
  logic [HDR_LEN_BITS-1:0] len_q;
  logic [HDR_LEN_BITS-1:0] remain_q;
  logic                    underrun_q;

  logic          has_data;
  logic          full_ready;
  logic          timeout_hit;
  logic          start_full;
  logic          start_part;
  logic          timer_clear;
  logic          timer_inc;
  logic          timer_at_max;
  logic [TW-1:0] timer_count;

  logic [PAD-1:0]   hdr_pad_unused;
  logic [WIDTH-1:0] hdr_word;

  assign has_data    = (fifo_data_count != '0);
  assign full_ready  = (fifo_data_count >= BURST_C);
  assign timeout_hit = (timer_count == TIMER_MAX);
  // A full burst wins when the timer expires on the same cycle the count reaches BURST.
  assign start_full  = (state_q == IDLE) && full_ready;
  assign start_part  = (state_q == IDLE) && has_data && !full_ready && timeout_hit;

  assign timer_clear = (state_q != IDLE) || !has_data || start_full || start_part;
  assign timer_inc   = (state_q == IDLE) && has_data && !full_ready && !timer_at_max;

  sat_counter #(
    .MAX (TIMEOUT),
    .W   (TW)
  ) u_idle_timer (
    .clk    (clk),
    .srst_n (srst_n),
    .clear  (timer_clear),
    .inc    (timer_inc),
    .count  (timer_count),
    .at_max (timer_at_max)
  );

  assign {hdr_pad_unused, hdr_word} = make_hdr({{PAD{1'b0}}, seq_q}, len_q);

  always_comb begin
    m_valid    = 1'b0;
    m_hdr      = 1'b0;
    m_last     = 1'b0;
    m_data     = '0;
    fifo_rd_en = 1'b0;
    case (state_q)
      HEADER: begin
        m_valid = 1'b1;
        m_hdr   = 1'b1;
        m_data  = hdr_word;
      end
      DATA: begin
        m_valid    = !fifo_empty;
        m_data     = fifo_dout;
        m_last     = (remain_q == HDR_LEN_BITS'(1));
        fifo_rd_en = !fifo_empty && m_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      len_q      <= '0;
      remain_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_full) begin
            len_q   <= BURST_LEN;
            state_q <= HEADER;
          end else if (start_part) begin
            len_q   <= HDR_LEN_BITS'(fifo_data_count);
            state_q <= HEADER;
          end
        end
        HEADER: begin
          if (m_ready) begin
            seq_q    <= seq_q + SEQ_W'(1);
            remain_q <= len_q;
            state_q  <= DATA;
          end
        end
        DATA: begin
          // This block is the only reader, so an empty fifo here is a protocol error.
          if (fifo_empty) underrun_q <= 1'b1;
          if (m_valid && m_ready) begin
            remain_q <= remain_q - HDR_LEN_BITS'(1);
            if (remain_q == HDR_LEN_BITS'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign underrun = underrun_q;

endmodule
